reg_bus_sequencer: RTL and testbench
====================================

# reg_bus_sequencer

Parametrised single-bus register/ALU block that runs one register-register instruction as a fixed micro-step sequence over an internal shared bus: Rb→Y, Rc→ALU→Z, Z→Ra or HI/LO. It generalises our bus datapath in three ways: configurable data width and register count, an optional hardwired-zero R0, and a start/busy/done handshake so a control unit issues whole operations instead of individual out/in strobes. It sits between the instruction decoder and the register/ALU resources of the CPU.

## Interface
- DATA_W, 32, data/bus width; ≥8, power of two
- NREGS, 16, general registers; power of two, ≥4
- R0_ZERO, 1, 1: R0 reads as 0 and writes to R0 are discarded; 0: R0 is an ordinary register
- SEL_W = log2(NREGS) (derived, not overridable)

- Clock  in  1  sole clock, rising edge
- clear  in  1  asynchronous, active-high reset
- start  in  1  request an operation; sampled only in IDLE
- op  in  4  operation code
- ra, rb, rc  in  SEL_W each  destination, first source, second source
- ld_en  in  1  external register load; honoured only in IDLE
- ld_sel  in  SEL_W  load target
- ld_data  in  DATA_W  load value
- rd_sel  in  SEL_W  observation select
- rd_data  out  DATA_W  combinational R[rd_sel] (0 for R0 when R0_ZERO=1)
- hi_out, lo_out  out  DATA_W  HI and LO registers
- busy  out  1  high in S_Y, S_Z, S_WB
- done  out  1  registered one-cycle completion pulse
- err  out  1  registered one-cycle illegal-op pulse

## Operation
- Opcodes: 0 ADD, 1 SUB (Rb−Rc), 2 AND, 3 OR, 4 SHR logical, 5 SHL, 6 ROR, 7 ROL, 8 MUL, 9 NEG (−Rb; rc ignored), 10 NOT (~Rb; rc ignored), 11–15 illegal.
- Arithmetic is modulo 2^DATA_W. Shift and rotate amounts are Rc[log2(DATA_W)−1:0].
- MUL: signed DATA_W×DATA_W → 2·DATA_W. HI ← upper half, LO ← lower half; ra ignored, no register write.
- Z is 2·DATA_W. Non-MUL ops zero the upper half; writeback uses Zlow only.
- The bus carries exactly one source per micro-step: S_Y drives R[rb], S_Z drives R[rc], S_WB drives Zlow, or Zhigh/Zlow for MUL.
- State machine:
  - IDLE: start & legal op → latch op/ra/rb/rc, go to S_Y. start & illegal op → err pulse, stay in IDLE, no state change.
  - S_Y: Y ← R[rb], go to S_Z.
  - S_Z: Z ← alu(Y, R[rc]), go to S_WB.
  - S_WB: R[ra] ← Zlow (or HI/LO for MUL), done ← 1, go to IDLE.
- start is ignored while busy; operands are not re-latched.
- ld_en is ignored while busy. In IDLE, ld_en writes R[ld_sel] ← ld_data at the edge.
- ld_en and start together in IDLE: the load is applied at the accepting edge, so the operation reads the loaded value.
- Writes to R0 with R0_ZERO=1 are discarded (loads and writeback alike).

## Timing
- Accept edge E0 (IDLE, start=1). E1: Y loaded. E2: Z loaded. E3: writeback.
- busy is high after E0 through E3. done is high for exactly the cycle after E3, when rd_data already shows the result.
- A new start is accepted in the done cycle, giving back-to-back throughput of one operation per 4 cycles.
- err is high for the cycle after the rejecting edge.
- Reset values (clear asserted): state IDLE; all registers, Y, Z, HI and LO = 0; busy=0, done=0, err=0; rd_data=0, hi_out=0, lo_out=0.
- clear takes effect immediately, without waiting for a clock edge.
- clear mid-operation abandons the sequence: no writeback and no done pulse.

## Test plan
- Load R2=5, R3=7; ADD ra=1, rb=2, rc=3 → busy for 3 cycles, done in cycle 4 after start, R1=12.
- Load R2=0, R3=1; SUB ra=4 → R4=0xFFFFFFFF. Then SHR R4 by R3 into R5 → R5=0x7FFFFFFF.
- Load R4=0xFFFFFFFD (−3), R5=7; MUL rb=4, rc=5 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; R1–R15 unchanged.
- Load R6=1, R7=0x21; ROR ra=8 → R8=0x80000000 (amount 1). ROL R8 by R7 → 0x00000001.
- op=15 → err pulse, busy stays 0, registers unchanged. ADD ra=0 → R0 still reads 0. start pulsed during S_Z → ignored, exactly one done.
- Start ADD, assert clear asynchronously in S_Z → busy falls without a clock edge, no done, all rd_data reads 0. After release, a new ADD completes normally.

Source files
------------

// File: rtl/reg_bus_sequencer.sv
// Single-bus register/ALU sequencer: runs one register-register op as Rb->Y, Rc->ALU->Z, Z->Ra (or HI/LO).
// Parametrised width/register count, optional hardwired-zero R0, start/busy/done handshake.
module reg_bus_sequencer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NREGS   = 16,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic                     Clock,
    input  logic                     clear,
    input  logic                     start,
    input  logic [3:0]               op,
    input  logic [$clog2(NREGS)-1:0] ra,
    input  logic [$clog2(NREGS)-1:0] rb,
    input  logic [$clog2(NREGS)-1:0] rc,
    input  logic                     ld_en,
    input  logic [$clog2(NREGS)-1:0] ld_sel,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic [$clog2(NREGS)-1:0] rd_sel,
    output logic [DATA_W-1:0]        rd_data,
    output logic [DATA_W-1:0]        hi_out,
    output logic [DATA_W-1:0]        lo_out,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned SEL_W = $clog2(NREGS);
    localparam int unsigned SH_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, S_Y, S_Z, S_WB} state_e;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
        OP_SHR = 4'd4, OP_SHL = 4'd5, OP_ROR = 4'd6, OP_ROL = 4'd7,
        OP_MUL = 4'd8, OP_NEG = 4'd9, OP_NOT = 4'd10
    } op_e;

    state_e                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [SEL_W-1:0]      ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic [DATA_W-1:0]     regs_q [NREGS];
    logic [DATA_W-1:0]     regs_d [NREGS];
    logic [DATA_W-1:0]     reg_view [NREGS];
    logic [DATA_W-1:0]     y_q, y_d;
    logic [2*DATA_W-1:0]   z_q, z_d;
    logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                  done_q, done_d, err_q, err_d;

    logic [DATA_W-1:0]     bus;
    logic [SH_W-1:0]       sh;
    logic [2*DATA_W-1:0]   dbl, dbl_r, dbl_l;
    logic [2*DATA_W-1:0]   a_sx, b_sx, prod;
    logic [DATA_W-1:0]     alu_lo;
    logic [2*DATA_W-1:0]   alu_res;

    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            reg_view[i] = (R0_ZERO && i == 0) ? '0 : regs_q[i];
        end
    end

    // One source on the bus per micro-step; MUL writeback takes HI straight from Z's upper half.
    always_comb begin
        bus = '0;
        case (state_q)
            S_Y:     bus = reg_view[rb_q];
            S_Z:     bus = reg_view[rc_q];
            S_WB:    bus = z_q[DATA_W-1:0];
            default: bus = '0;
        endcase
    end

    always_comb begin
        sh     = bus[SH_W-1:0];
        dbl    = {y_q, y_q};
        dbl_r  = dbl >> sh;
        dbl_l  = dbl << sh;
        a_sx   = {{DATA_W{y_q[DATA_W-1]}}, y_q};
        b_sx   = {{DATA_W{bus[DATA_W-1]}}, bus};
        prod   = a_sx * b_sx;
        alu_lo = '0;
        case (op_q)
            OP_ADD:  alu_lo = y_q + bus;
            OP_SUB:  alu_lo = y_q - bus;
            OP_AND:  alu_lo = y_q & bus;
            OP_OR:   alu_lo = y_q | bus;
            OP_SHR:  alu_lo = y_q >> sh;
            OP_SHL:  alu_lo = y_q << sh;
            OP_ROR:  alu_lo = dbl_r[DATA_W-1:0];
            OP_ROL:  alu_lo = dbl_l[2*DATA_W-1:DATA_W];
            OP_NEG:  alu_lo = '0 - y_q;
            OP_NOT:  alu_lo = ~y_q;
            default: alu_lo = '0;
        endcase
        alu_res = (op_q == OP_MUL) ? prod : {{DATA_W{1'b0}}, alu_lo};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        regs_d  = regs_q;
        y_d     = y_q;
        z_d     = z_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_en && !(R0_ZERO && ld_sel == '0)) begin
                    regs_d[ld_sel] = ld_data;
                end
                if (start) begin
                    if (op <= OP_NOT) begin
                        op_d    = op;
                        ra_d    = ra;
                        rb_d    = rb;
                        rc_d    = rc;
                        state_d = S_Y;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_Y: begin
                y_d     = bus;
                state_d = S_Z;
            end
            S_Z: begin
                z_d     = alu_res;
                state_d = S_WB;
            end
            S_WB: begin
                if (op_q == OP_MUL) begin
                    hi_d = z_q[2*DATA_W-1:DATA_W];
                    lo_d = bus;
                end else if (!(R0_ZERO && ra_q == '0)) begin
                    regs_d[ra_q] = bus;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            regs_q  <= regs_d;
            y_q     <= y_d;
            z_q     <= z_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rd_data = reg_view[rd_sel];
    assign hi_out  = hi_q;
    assign lo_out  = lo_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Scoreboard bench for reg_bus_sequencer: expected results queued at issue, popped on done.
module tb_reg_bus_sequencer;

    localparam int W  = 32;
    localparam int NR = 16;

    logic          Clock = 1'b0;
    logic          clear = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    op = '0;
    logic [3:0]    ra = '0, rb = '0, rc = '0, ld_sel = '0, rd_sel = '0;
    logic          ld_en = 1'b0;
    logic [W-1:0]  ld_data = '0;
    logic [W-1:0]  rd_data, hi_out, lo_out;
    logic          busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mreg [NR];
    logic [W-1:0] mhi, mlo;

    typedef struct packed {
        logic [3:0]   op;
        logic [3:0]   ra;
        logic [W-1:0] val;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb[$];

    reg_bus_sequencer #(.DATA_W(W), .NREGS(NR), .R0_ZERO(1'b1)) dut (
        .Clock(Clock), .clear(clear), .start(start), .op(op),
        .ra(ra), .rb(rb), .rc(rc),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
        .rd_sel(rd_sel), .rd_data(rd_data), .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 Clock = ~Clock;

    function automatic logic [W-1:0] rot_r(input logic [W-1:0] a, input int n);
        for (int i = 0; i < n; i++) a = {a[0], a[W-1:1]};
        return a;
    endfunction

    function automatic logic [W-1:0] rot_l(input logic [W-1:0] a, input int n);
        for (int i = 0; i < n; i++) a = {a[W-2:0], a[W-1]};
        return a;
    endfunction

    function automatic logic [2*W-1:0] model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int    n;
        longint p;
        n = int'(b[4:0]);
        case (o)
            4'd0:    return {32'h0, a + b};
            4'd1:    return {32'h0, a - b};
            4'd2:    return {32'h0, a & b};
            4'd3:    return {32'h0, a | b};
            4'd4:    return {32'h0, a >> n};
            4'd5:    return {32'h0, a << n};
            4'd6:    return {32'h0, rot_r(a, n)};
            4'd7:    return {32'h0, rot_l(a, n)};
            4'd8: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            4'd9:    return {32'h0, 32'h0 - a};
            default: return {32'h0, ~a};
        endcase
    endfunction

    task automatic do_load(input logic [3:0] sel, input logic [W-1:0] val);
        ld_en = 1'b1; ld_sel = sel; ld_data = val;
        @(posedge Clock); #1;
        ld_en = 1'b0;
        if (sel != 4'd0) mreg[sel] = val;
    endtask

    task automatic issue(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        exp_t e;
        logic [2*W-1:0] r;
        r = model(o, mreg[b], mreg[c]);
        e.op = o; e.ra = a; e.val = r[W-1:0]; e.hi = r[2*W-1:W]; e.lo = r[W-1:0];
        if (o == 4'd8) {mhi, mlo} = r;
        else if (a != 4'd0) mreg[a] = r[W-1:0];
        sb.push_back(e);
        op = o; ra = a; rb = b; rc = c; start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bcyc, output bit ok);
        cyc = 0; bcyc = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bcyc++;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, err}); end
        checks++; if ({hi_out, lo_out} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h want 0", {hi_out, lo_out}); end
        for (int i = 0; i < NR; i++) begin
            rd_sel = 4'(i); #1;
            checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_r%0d got %h want 0", i, rd_data); end
        end
        @(negedge Clock);
        clear = 1'b0;
    endtask

    task automatic test_add();
        int cyc, bcyc; bit ok; exp_t e;
        do_load(4'd2, 32'd5);
        do_load(4'd3, 32'd7);
        issue(4'd0, 4'd1, 4'd2, 4'd3);
        wait_done(cyc, bcyc, ok);
        checks++; if (!ok || cyc != 4) begin errors++; $display("FAIL add_latency got %0d want 4", cyc); end
        checks++; if (bcyc != 3) begin errors++; $display("FAIL add_busy_cycles got %0d want 3", bcyc); end
        e = sb.pop_front();
        rd_sel = e.ra; #1;
        checks++; if (rd_data !== e.val) begin errors++; $display("FAIL add_r1 got %h want %h", rd_data, e.val); end
    endtask

    task automatic test_sub_shr();
        int cyc, bcyc; bit ok; exp_t e;
        do_load(4'd2, 32'd0);
        do_load(4'd3, 32'd1);
        issue(4'd1, 4'd4, 4'd2, 4'd3);
        wait_done(cyc, bcyc, ok);
        e = sb.pop_front(); rd_sel = e.ra; #1;
        checks++; if (!ok || rd_data !== e.val) begin errors++; $display("FAIL sub_r4 got %h want %h", rd_data, e.val); end
        issue(4'd4, 4'd5, 4'd4, 4'd3);
        wait_done(cyc, bcyc, ok);
        e = sb.pop_front(); rd_sel = e.ra; #1;
        checks++; if (!ok || rd_data !== e.val) begin errors++; $display("FAIL shr_r5 got %h want %h", rd_data, e.val); end
    endtask

    task automatic test_mul();
        int cyc, bcyc; bit ok; exp_t e;
        do_load(4'd4, 32'hFFFF_FFFD);
        do_load(4'd5, 32'd7);
        issue(4'd8, 4'd1, 4'd4, 4'd5);
        wait_done(cyc, bcyc, ok);
        e = sb.pop_front();
        checks++; if (!ok || hi_out !== e.hi) begin errors++; $display("FAIL mul_hi got %h want %h", hi_out, e.hi); end
        checks++; if (lo_out !== e.lo) begin errors++; $display("FAIL mul_lo got %h want %h", lo_out, e.lo); end
        for (int i = 1; i < NR; i++) begin
            rd_sel = 4'(i); #1;
            checks++; if (rd_data !== mreg[i]) begin errors++; $display("FAIL mul_keep_r%0d got %h want %h", i, rd_data, mreg[i]); end
        end
    endtask

    task automatic test_rotate();
        int cyc, bcyc; bit ok; exp_t e;
        do_load(4'd6, 32'd1);
        do_load(4'd7, 32'h21);
        issue(4'd6, 4'd8, 4'd6, 4'd7);
        wait_done(cyc, bcyc, ok);
        e = sb.pop_front(); rd_sel = e.ra; #1;
        checks++; if (!ok || rd_data !== e.val) begin errors++; $display("FAIL ror_r8 got %h want %h", rd_data, e.val); end
        issue(4'd7, 4'd9, 4'd8, 4'd7);
        wait_done(cyc, bcyc, ok);
        e = sb.pop_front(); rd_sel = e.ra; #1;
        checks++; if (!ok || rd_data !== e.val) begin errors++; $display("FAIL rol_r9 got %h want %h", rd_data, e.val); end
    endtask

    task automatic test_illegal();
        @(negedge Clock);
        op = 4'd15; ra = 4'd1; rb = 4'd2; rc = 4'd3; start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        @(negedge Clock);
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL illegal_err got err=%b busy=%b want 1 0", err, busy); end
        @(negedge Clock);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_pulse got %b want 0", err); end
        for (int i = 0; i < NR; i++) begin
            rd_sel = 4'(i); #1;
            checks++; if (rd_data !== mreg[i]) begin errors++; $display("FAIL illegal_keep_r%0d got %h want %h", i, rd_data, mreg[i]); end
        end
    endtask

    task automatic test_r0();
        int cyc, bcyc; bit ok; exp_t e;
        do_load(4'd0, 32'd123);
        rd_sel = 4'd0; #1;
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL r0_load got %h want 0", rd_data); end
        issue(4'd0, 4'd0, 4'd2, 4'd3);
        wait_done(cyc, bcyc, ok);
        e = sb.pop_front(); rd_sel = 4'd0; #1;
        checks++; if (!ok || rd_data !== mreg[0]) begin errors++; $display("FAIL r0_wb got %h want %h", rd_data, mreg[0]); end
    endtask

    task automatic test_start_ignored();
        int ndone; exp_t e;
        do_load(4'd2, 32'd40);
        do_load(4'd3, 32'd2);
        issue(4'd0, 4'd9, 4'd2, 4'd3);
        @(negedge Clock);
        @(negedge Clock);
        op = 4'd1; ra = 4'd10; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (done) ndone++;
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignored_start_dones got %0d want 1", ndone); end
        e = sb.pop_front(); rd_sel = e.ra; #1;
        checks++; if (rd_data !== e.val) begin errors++; $display("FAIL ignored_start_r9 got %h want %h", rd_data, e.val); end
        rd_sel = 4'd10; #1;
        checks++; if (rd_data !== mreg[10]) begin errors++; $display("FAIL ignored_start_r10 got %h want %h", rd_data, mreg[10]); end
    endtask

    task automatic test_ld_start();
        int cyc, bcyc; bit ok; exp_t e;
        ld_en = 1'b1; ld_sel = 4'd2; ld_data = 32'd100;
        mreg[2] = 32'd100;
        issue(4'd0, 4'd11, 4'd2, 4'd3);
        ld_en = 1'b0;
        wait_done(cyc, bcyc, ok);
        e = sb.pop_front(); rd_sel = e.ra; #1;
        checks++; if (!ok || rd_data !== e.val) begin errors++; $display("FAIL ld_start_r11 got %h want %h", rd_data, e.val); end
    endtask

    task automatic test_clear_mid();
        int cyc, bcyc, ndone; bit ok; exp_t e;
        issue(4'd0, 4'd12, 4'd2, 4'd3);
        @(negedge Clock);
        @(negedge Clock);
        #2 clear = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy got %b want 0", busy); end
        sb.delete();
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        mhi = '0; mlo = '0;
        for (int i = 0; i < NR; i++) begin
            rd_sel = 4'(i); #1;
            checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL clear_r%0d got %h want 0", i, rd_data); end
        end
        checks++; if ({hi_out, lo_out} !== 64'h0) begin errors++; $display("FAIL clear_hilo got %h want 0", {hi_out, lo_out}); end
        @(negedge Clock);
        clear = 1'b0;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL clear_no_done got %0d want 0", ndone); end
        do_load(4'd2, 32'd20);
        do_load(4'd3, 32'd22);
        issue(4'd0, 4'd12, 4'd2, 4'd3);
        wait_done(cyc, bcyc, ok);
        e = sb.pop_front(); rd_sel = e.ra; #1;
        checks++; if (!ok || rd_data !== e.val) begin errors++; $display("FAIL clear_recover_r12 got %h want %h", rd_data, e.val); end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc; bit ok; exp_t e;
        logic [3:0] ops [6];
        ops = '{4'd2, 4'd3, 4'd5, 4'd9, 4'd10, 4'd1};
        do_load(4'd2, 32'hF0F0_1234);
        do_load(4'd3, 32'h0000_0F03);
        issue(4'd0, 4'd13, 4'd2, 4'd3);
        for (int k = 0; k <= 6; k++) begin
            wait_done(cyc, bcyc, ok);
            checks++; if (!ok || cyc != 4) begin errors++; $display("FAIL b2b_latency_%0d got %0d want 4", k, cyc); end
            e = sb.pop_front(); rd_sel = e.ra; #1;
            checks++; if (rd_data !== e.val) begin errors++; $display("FAIL b2b_result_%0d got %h want %h", k, rd_data, e.val); end
            if (k < 6) issue(ops[k], 4'd14, 4'd13, 4'd3);
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        mhi = '0; mlo = '0;
        test_reset();
        test_add();
        test_sub_shr();
        test_mul();
        test_rotate();
        test_illegal();
        test_r0();
        test_start_ignored();
        test_ld_start();
        test_clear_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
